// File: rtl/multi_lane_inst_queue_if.sv
// multi_lane_inst_queue_if: decode-side and front-end-side bundle for the
// multi-lane instruction queue. Clock and reset stay as plain module ports.
interface multi_lane_inst_queue_if #(
    parameter int entryWidth     = 302,
    parameter int queueIndexBits = 4,
    parameter int enqLanes       = 2,
    parameter int deqLanes       = 2
);
    logic                               flush_i;
    logic [2:0]                         enqCount_i;
    logic [enqLanes*entryWidth-1:0]     enqData_i;
    logic [2:0]                         deqCount_i;
    logic [deqLanes*entryWidth-1:0]     deqData_o;
    logic [deqLanes-1:0]                deqValid_o;
    logic [queueIndexBits:0]            count_o;
    logic [queueIndexBits:0]            freeCount_o;
    logic                               isEmpty_o;
    logic                               isFull_o;
    logic                               almostFull_o;
    logic                               overflow_o;

    // Producer/consumer side (decode + front end)
    modport master (
        output flush_i, enqCount_i, enqData_i, deqCount_i,
        input  deqData_o, deqValid_o, count_o, freeCount_o,
               isEmpty_o, isFull_o, almostFull_o, overflow_o
    );

    // Queue side
    modport slave (
        input  flush_i, enqCount_i, enqData_i, deqCount_i,
        output deqData_o, deqValid_o, count_o, freeCount_o,
               isEmpty_o, isFull_o, almostFull_o, overflow_o
    );
endinterface

// File: rtl/multi_lane_inst_queue.sv
// multi_lane_inst_queue: multi-lane circular FIFO between decode and the
// out-of-order front end. Whole-request enqueue acceptance, program-order
// multi-lane dequeue, exact occupancy, flush, almost-full and sticky overflow.
module multi_lane_inst_queue #(
  parameter int entryWidth       = 302,
  parameter int queueIndexBits   = 4,
  parameter int enqLanes         = 2,
  parameter int deqLanes         = 2,
  parameter int almostFullThresh = 12,
  parameter int IOQInstance      = 0
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  multi_lane_inst_queue_if.slave  ioq
);
  localparam int unsigned DEPTH = 2 ** queueIndexBits;
  localparam int          CW    = queueIndexBits + 1;

  typedef logic [queueIndexBits-1:0] ptr_t;
  typedef logic [CW-1:0]             cnt_t;

  logic [entryWidth-1:0] mem [DEPTH];

  ptr_t                head;
  ptr_t                tail;
  cnt_t                count;
  cnt_t                count_next;
  logic [31:0]         enq_n;
  logic [31:0]         deq_n;
  logic [31:0]         free_n;
  logic [31:0]         grant_n;
  logic                enq_ok;
  logic                enq_rej;
  logic [deqLanes-1:0] valid_next;

  assign ioq.count_o = count;

  always_comb begin
    enq_n   = 32'(ioq.enqCount_i);
    deq_n   = 32'(ioq.deqCount_i);
    free_n  = 32'(DEPTH) - 32'(count);
    enq_ok  = (enq_n != 32'd0) && (enq_n <= 32'(enqLanes)) && (enq_n <= free_n);
    enq_rej = (enq_n != 32'd0) && !enq_ok;
    grant_n = deq_n;
    if (32'(count) < grant_n)    grant_n = 32'(count);
    if (32'(deqLanes) < grant_n) grant_n = 32'(deqLanes);
    count_next = cnt_t'(32'(count) + (enq_ok ? enq_n : 32'd0) - grant_n);
    valid_next = '0;
    for (int unsigned k = 0; k < deqLanes; k++) begin
      valid_next[k] = (k < grant_n);
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      ioq.freeCount_o  <= cnt_t'(DEPTH);
      ioq.isEmpty_o    <= 1'b1;
      ioq.isFull_o     <= 1'b0;
      ioq.almostFull_o <= 1'b0;
      ioq.overflow_o   <= 1'b0;
      ioq.deqValid_o   <= '0;
      ioq.deqData_o    <= '0;
    end else if (ioq.flush_i) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      ioq.freeCount_o  <= cnt_t'(DEPTH);
      ioq.isEmpty_o    <= 1'b1;
      ioq.isFull_o     <= 1'b0;
      ioq.almostFull_o <= 1'b0;
      ioq.overflow_o   <= 1'b0;
      ioq.deqValid_o   <= '0;
    end else begin
      head             <= head + ptr_t'(grant_n);
      tail             <= tail + (enq_ok ? ptr_t'(enq_n) : ptr_t'(0));
      count            <= count_next;
      ioq.freeCount_o  <= cnt_t'(DEPTH) - count_next;
      ioq.isEmpty_o    <= (count_next == '0);
      ioq.isFull_o     <= (count_next == cnt_t'(DEPTH));
      ioq.almostFull_o <= (32'(count_next) >= 32'(almostFullThresh));
      if (enq_rej) ioq.overflow_o <= 1'b1;
      ioq.deqValid_o   <= valid_next;
      for (int unsigned k = 0; k < deqLanes; k++) begin
        ioq.deqData_o[k*entryWidth +: entryWidth] <= mem[head + ptr_t'(k)];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i && !ioq.flush_i && enq_ok) begin
      for (int unsigned k = 0; k < enqLanes; k++) begin
        if (k < enq_n) begin
          mem[tail + ptr_t'(k)] <= ioq.enqData_i[k*entryWidth +: entryWidth];
        end
      end
    end
  end

`ifdef IOQ_DEBUG_LOG_EN
  logic log_on;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      log_on <= 1'b0;
    end else begin
      log_on <= 1'b1;
      if (log_on) begin
        if (ioq.flush_i) begin
          $display("IOQ%0d %0t flush", IOQInstance, $time);
        end else begin
          for (int unsigned k = 0; k < enqLanes; k++) begin
            if (enq_ok && k < enq_n)
              $display("IOQ%0d %0t enq slot %0d lane %0d", IOQInstance, $time, tail + ptr_t'(k), k);
          end
          for (int unsigned k = 0; k < deqLanes; k++) begin
            if (k < grant_n)
              $display("IOQ%0d %0t deq slot %0d lane %0d", IOQInstance, $time, head + ptr_t'(k), k);
          end
          if (enq_rej) $display("IOQ%0d %0t overflow req %0d", IOQInstance, $time, enq_n);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_lane_inst_queue.sv
// tb_multi_lane_inst_queue: table-driven vectors plus hand sequences, with a
// queue-based reference model feeding a scoreboard of expected dequeue data.
module tb_multi_lane_inst_queue;
    localparam int EW = 302;

    logic clock_i;
    logic reset_i;

    multi_lane_inst_queue_if #(
        .entryWidth(EW), .queueIndexBits(4), .enqLanes(2), .deqLanes(2)
    ) ioq ();

    multi_lane_inst_queue #(
        .entryWidth(EW), .queueIndexBits(4), .enqLanes(2), .deqLanes(2),
        .almostFullThresh(12), .IOQInstance(0)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .ioq     (ioq)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    int n_chk = 0;
    int n_err = 0;

    logic [EW-1:0] model_q [$];   // reference queue contents
    logic [EW-1:0] exp_q   [$];   // scoreboard of expected dequeued entries
    bit            m_ovf;
    int            next_tag;

    typedef struct {
        bit         fl;
        int         enq;
        int         deq;
        int         exp_cnt;
        logic [1:0] exp_vld;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [EW-1:0] mk(input int t);
        logic [15:0] s;
        s = 16'(t);
        return EW'({19{s}});
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock of stimulus with model update, then full output check
    task automatic step(input bit fl, input int enq, input int deq);
        int sz, gr;
        bit acc;
        logic [1:0] ev;
        logic [EW-1:0] e;
        sz = model_q.size();
        ioq.flush_i    = fl;
        ioq.enqCount_i = 3'(enq);
        ioq.deqCount_i = 3'(deq);
        for (int k = 0; k < 2; k++) ioq.enqData_i[k*EW +: EW] = mk(next_tag + k);
        ev = '0;
        if (fl) begin
            model_q.delete();
            m_ovf = 1'b0;
        end else begin
            gr = deq;
            if (sz < gr) gr = sz;
            if (2 < gr)  gr = 2;
            for (int k = 0; k < gr; k++) begin
                exp_q.push_back(model_q.pop_front());
                ev[k] = 1'b1;
            end
            acc = (enq != 0) && (enq <= 2) && (enq <= 16 - sz);
            if (acc) begin
                for (int k = 0; k < enq; k++) model_q.push_back(mk(next_tag + k));
                next_tag += enq;
            end else if (enq != 0) begin
                m_ovf = 1'b1;
            end
        end
        @(posedge clock_i);
        #1;
        chk("deq_valid", 320'(ioq.deqValid_o), 320'(ev));
        for (int k = 0; k < 2; k++) begin
            if (ev[k]) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underrun", 320'(1), 320'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("deq_data_lane%0d", k), 320'(ioq.deqData_o[k*EW +: EW]), 320'(e));
                end
            end
        end
        sz = model_q.size();
        chk("count",      320'(ioq.count_o),      320'(sz));
        chk("free_count", 320'(ioq.freeCount_o),  320'(16 - sz));
        chk("is_empty",   320'(ioq.isEmpty_o),    320'(sz == 0));
        chk("is_full",    320'(ioq.isFull_o),     320'(sz == 16));
        chk("almost_full",320'(ioq.almostFull_o), 320'(sz >= 12));
        chk("overflow",   320'(ioq.overflow_o),   320'(m_ovf));
        ioq.flush_i    = 1'b0;
        ioq.enqCount_i = '0;
        ioq.deqCount_i = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"},   320'(ioq.count_o),      320'(0));
        chk({tag, "_free"},    320'(ioq.freeCount_o),  320'(16));
        chk({tag, "_empty"},   320'(ioq.isEmpty_o),    320'(1));
        chk({tag, "_full"},    320'(ioq.isFull_o),     320'(0));
        chk({tag, "_afull"},   320'(ioq.almostFull_o), 320'(0));
        chk({tag, "_ovf"},     320'(ioq.overflow_o),   320'(0));
        chk({tag, "_valid"},   320'(ioq.deqValid_o),   320'(0));
        chk({tag, "_data"},    320'(ioq.deqData_o[EW-1:0]), 320'(0));
        chk({tag, "_data1"},   320'(ioq.deqData_o[2*EW-1:EW]), 320'(0));
    endtask

    initial begin
        // fill: 8x enq2 -> 16; overflow; full both-ways; flush+enq; empty both-ways;
        // over-wide deq; over-wide enq; flush
        for (int i = 0; i < 8; i++) tbl[i] = '{0, 2, 0, 2*(i+1), 2'b00};
        tbl[8]  = '{0, 1, 0, 16, 2'b00};
        tbl[9]  = '{0, 2, 2, 14, 2'b11};
        tbl[10] = '{1, 2, 0, 0,  2'b00};
        tbl[11] = '{0, 2, 2, 2,  2'b00};
        tbl[12] = '{0, 0, 3, 0,  2'b11};
        tbl[13] = '{0, 3, 0, 0,  2'b00};
        tbl[14] = '{1, 0, 0, 0,  2'b00};

        reset_i        = 1'b0;
        ioq.flush_i    = 1'b0;
        ioq.enqCount_i = '0;
        ioq.deqCount_i = '0;
        ioq.enqData_i  = '0;
        m_ovf          = 1'b0;
        next_tag       = 0;
        #12;
        chk_reset_vals("reset");
        @(negedge clock_i);
        reset_i = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].fl, tbl[i].enq, tbl[i].deq);
            chk($sformatf("tbl%0d_count", i), 320'(ioq.count_o),    320'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_valid", i), 320'(ioq.deqValid_o), 320'(tbl[i].exp_vld));
        end

        // Pointer wrap: tags 0..11 in, 10 out, 10 more in, 12 out as 10..21
        next_tag = 0;
        for (int i = 0; i < 6; i++) step(0, 2, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 2);
        for (int i = 0; i < 5; i++) step(0, 2, 0);
        chk("wrap_count", 320'(ioq.count_o), 320'(12));
        step(0, 0, 2);
        chk("wrap_first_tag", 320'(ioq.deqData_o[EW-1:0]),    320'(mk(10)));
        chk("wrap_second_tag",320'(ioq.deqData_o[2*EW-1:EW]), 320'(mk(11)));
        for (int i = 0; i < 5; i++) step(0, 0, 2);

        // Partial grant at count 1
        step(0, 1, 0);
        step(0, 0, 2);
        chk("partial_valid", 320'(ioq.deqValid_o), 320'(2'b01));
        chk("partial_empty", 320'(ioq.isEmpty_o),  320'(1));

        // Simultaneous enq2/deq2 at count 3
        step(0, 2, 0);
        step(0, 1, 0);
        step(0, 2, 2);
        chk("simul_count", 320'(ioq.count_o), 320'(3));
        step(0, 0, 2);
        step(0, 0, 2);
        step(0, 0, 2);

        // Flush at count 9 wins over enqueue
        for (int i = 0; i < 4; i++) step(0, 2, 0);
        step(0, 1, 0);
        chk("pre_flush_count", 320'(ioq.count_o), 320'(9));
        step(1, 2, 0);
        chk("flush_count", 320'(ioq.count_o),   320'(0));
        chk("flush_empty", 320'(ioq.isEmpty_o), 320'(1));

        // Asynchronous reset mid-fill, checked before the next clock edge
        step(0, 2, 0);
        step(0, 2, 0);
        step(0, 1, 2);
        #1 reset_i = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        model_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        @(negedge clock_i);
        reset_i = 1'b1;
        step(0, 2, 0);
        step(0, 0, 2);
        step(0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
